debounced_input: RTL and testbench

Conditions a raw, pulled-up ice40 input pin into a clean, synchronous logical level with single-cycle edge events. Sits directly downstream of the pull-up input buffer; takes its `value` output as `raw`. Chain: metastability synchronizer, then debounce state machine with stability counter. Output feeds user logic such as buttons, mode straps and slow external strobes.

---
 rtl/input_conditioning_pkg.sv | 20 ++
 rtl/sync_chain.sv | 28 ++
 rtl/debounced_input.sv | 182 ++++++++++++++++++
 tb/tb_debounced_input.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioning_pkg.sv
// Shared definitions for the input conditioning blocks: debounce state
// encoding and a helper that sizes counters able to hold a given count.
package input_conditioning_pkg;

   typedef logic [1:0] dbState_t;

   // Stable and pending states for each debounced level
   localparam dbState_t S_IDLE0 = 2'b00;
   localparam dbState_t S_PEND1 = 2'b01;
   localparam dbState_t S_IDLE1 = 2'b11;
   localparam dbState_t S_PEND0 = 2'b10;

   // Bits needed to represent every value from 0 up to maxCount inclusive
   function automatic int counterWidth(input int maxCount);
      if (maxCount < 1)
         return 1;
      return $clog2(maxCount + 1);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop metastability synchronizer for an asynchronous single-bit input.
// STAGES flops in series; all of them reset to RESET_VAL so the chain starts
// out holding the idle level of the pin it is attached to.
module sync_chain
   import input_conditioning_pkg::*;
#(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_stages;

   // Shift the raw value through the chain, oldest sample at the top bit
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_stages <= {STAGES{RESET_VAL}};
      else
         r_stages <= {r_stages[STAGES-2:0], i_d};
   end

   assign o_q = r_stages[STAGES-1];

endmodule

// File: rtl/debounced_input.sv
// Debounced input conditioner for a pulled-up pin: synchronizer, debounce
// state machine with stability counter, and registered rise/fall pulses.
// Optional long-press detector enabled by defining DEBOUNCED_INPUT_LONGPRESS_EN;
// without it long_press is tied low and the port list is unchanged.
module debounced_input
   import input_conditioning_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1000,
   parameter int ACTIVE_LOW    = 1,
   parameter int LONG_CYCLES   = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   // Idle pin level: a pulled-up pin idles high when active-low
   localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

   localparam int           CW       = counterWidth(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Parameter legality guards, evaluated at elaboration only
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_badSyncStages
      $error("debounced_input: SYNC_STAGES must be 2..4");
   end
   if (STABLE_CYCLES < 1) begin : g_badStableCycles
      $error("debounced_input: STABLE_CYCLES must be at least 1");
   end
   if (LONG_CYCLES < 1) begin : g_badLongCycles
      $error("debounced_input: LONG_CYCLES must be at least 1");
   end

   logic          w_synced;
   logic          w_s;
   dbState_t      r_state;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   dbState_t      w_nextState;
   logic [CW-1:0] w_nextCnt;
   logic          w_commitRise;
   logic          w_commitFall;

   sync_chain #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RAW_IDLE)
   ) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (raw),
      .o_q   (w_synced)
   );

   // Polarity-corrected synchronized sample: 1 means the pin is active
   assign w_s = w_synced ^ RAW_IDLE;

   // Next-state logic: start a count on a change, drop it on a glitch,
   // commit once the new value has been seen STABLE_CYCLES times in a row
   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_commitRise = 1'b0;
      w_commitFall = 1'b0;
      case (r_state)
         S_IDLE0: begin
            if (w_s) begin
               if (STABLE_CYCLES == 1) begin
                  w_nextState  = S_IDLE1;
                  w_nextCnt    = '0;
                  w_commitRise = 1'b1;
               end else begin
                  w_nextState = S_PEND1;
                  w_nextCnt   = CNT_ONE;
               end
            end
         end
         S_PEND1: begin
            if (!w_s) begin
               w_nextState = S_IDLE0;
               w_nextCnt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState  = S_IDLE1;
               w_nextCnt    = '0;
               w_commitRise = 1'b1;
            end else begin
               w_nextCnt = r_cnt + CNT_ONE;
            end
         end
         S_IDLE1: begin
            if (!w_s) begin
               if (STABLE_CYCLES == 1) begin
                  w_nextState  = S_IDLE0;
                  w_nextCnt    = '0;
                  w_commitFall = 1'b1;
               end else begin
                  w_nextState = S_PEND0;
                  w_nextCnt   = CNT_ONE;
               end
            end
         end
         S_PEND0: begin
            if (w_s) begin
               w_nextState = S_IDLE1;
               w_nextCnt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState  = S_IDLE0;
               w_nextCnt    = '0;
               w_commitFall = 1'b1;
            end else begin
               w_nextCnt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_nextState = S_IDLE0;
            w_nextCnt   = '0;
         end
      endcase
   end

   // State, stability counter, level and single-cycle edge registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_rise  <= w_commitRise;
         r_fall  <= w_commitFall;
         if (w_commitRise)
            r_level <= 1'b1;
         else if (w_commitFall)
            r_level <= 1'b0;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;

`ifdef DEBOUNCED_INPUT_LONGPRESS_EN
   localparam int            LW        = counterWidth(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

   logic [LW-1:0] r_longCnt;
   logic          r_longPulse;

   // Count cycles at level 1, pulse once on reaching LONG_CYCLES, then hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_longCnt   <= '0;
         r_longPulse <= 1'b0;
      end else begin
         r_longPulse <= 1'b0;
         if (!r_level) begin
            r_longCnt <= '0;
         end else if (r_longCnt != LONG_MAX) begin
            r_longCnt <= r_longCnt + LW'(1);
            if (r_longCnt == LONG_LAST)
               r_longPulse <= 1'b1;
         end
      end
   end

   assign long_press = r_longPulse;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounced_input.sv
// Self-checking bench for debounced_input with a per-cycle scoreboard.
// Expected outputs come from a behavioural model of the debounce rule:
// the level follows the synchronized pin once the pin has differed from the
// level for STABLE consecutive samples.
module tb_debounced_input;

   localparam int   SYNC   = 2;
   localparam int   STABLE = 4;
   localparam int   ACTLOW = 1;
   localparam int   LONG   = 20;
   localparam logic IDLE_RAW = 1'b1;

   logic clk;
   logic rst;
   logic raw;
   logic level;
   logic rise;
   logic fall;
   logic long_press;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] expQ[$];

   logic [SYNC-1:0] mPipe;
   logic            mLevel;
   int              mRun;
   int              mLong;

   int edgeNum       = 0;
   int lastDriveEdge = 0;
   int riseCnt = 0, fallCnt = 0, longCnt = 0;
   int riseEdge = -1, fallEdge = -1, longEdge = -1;

   debounced_input #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .ACTIVE_LOW    (ACTLOW),
      .LONG_CYCLES   (LONG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw        (raw),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .long_press (long_press)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count a comparison and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at edge %0d",
                  tag, observed, expected, edgeNum);
      end
   endtask

   task automatic modelReset();
      mPipe  = {SYNC{IDLE_RAW}};
      mLevel = 1'b0;
      mRun   = 0;
      mLong  = 0;
   endtask

   // Advance the model by one clock edge and queue the outputs it predicts
   task automatic modelStep();
      logic sSeen;
      logic lvlBefore;
      logic eRise, eFall, eLong;
      eRise = 1'b0;
      eFall = 1'b0;
      eLong = 1'b0;
      sSeen = mPipe[SYNC-1] ^ IDLE_RAW;
      mPipe = {mPipe[SYNC-2:0], raw};
      lvlBefore = mLevel;
      if (sSeen != mLevel) begin
         mRun++;
         if (mRun == STABLE) begin
            mLevel = sSeen;
            eRise  = sSeen;
            eFall  = !sSeen;
            mRun   = 0;
         end
      end else begin
         mRun = 0;
      end
`ifdef DEBOUNCED_INPUT_LONGPRESS_EN
      if (lvlBefore) begin
         if (mLong < LONG) begin
            mLong++;
            if (mLong == LONG)
               eLong = 1'b1;
         end
      end else begin
         mLong = 0;
      end
`else
      mLong = lvlBefore ? mLong : 0;
`endif
      expQ.push_back({mLevel, eRise, eFall, eLong});
   endtask

   // Drive one cycle of stimulus on the falling edge and queue its expectation
   task automatic applyStimulus(input logic rawVal, input logic rstVal);
      @(negedge clk);
      raw = rawVal;
      rst = rstVal;
      lastDriveEdge = edgeNum + 1;
      if (rstVal) begin
         modelReset();
         #1;
         checkOutput("rstAsync", {level, rise, fall, long_press}, 4'b0000);
      end
      @(posedge clk);
      if (rstVal)
         expQ.push_back(4'b0000);
      else
         modelStep();
   endtask

   // Monitor: compare each cycle's outputs shortly after the edge
   always @(posedge clk) begin
      logic [3:0] expVal;
      if (rst)
         edgeNum = 0;
      else
         edgeNum++;
      #2;
      if (expQ.size() > 0) begin
         expVal = expQ.pop_front();
         checkOutput("cycle", {level, rise, fall, long_press}, expVal);
      end
      if (rise) begin riseCnt++; riseEdge = edgeNum; end
      if (fall) begin fallCnt++; fallEdge = edgeNum; end
      if (long_press) begin longCnt++; longEdge = edgeNum; end
   end

   initial begin
      int riseBase, fallBase, longBase, finalEdge, pressEdge;
      rst = 1'b1;
      raw = 1'b1;
      modelReset();

      // Reset with the pin idle, then hold idle
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("idleRiseCnt", riseCnt, 0);

      // Press before edge 10: level commits on edge 15
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("pressRiseCnt", riseCnt, 1);
      checkOutput("pressRiseEdge", riseEdge, 15);
      checkOutput("pressFallCnt", fallCnt, 0);

      // Three-sample release glitch is ignored, real release falls 5 edges later
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("glitchFallCnt", fallCnt, 0);
      checkOutput("glitchLevel", level, 1);
      applyStimulus(1'b1, 1'b0);
      finalEdge = lastDriveEdge;
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("releaseFallCnt", fallCnt, 1);
      checkOutput("releaseFallEdge", fallEdge, finalEdge + 5);
      checkOutput("releaseLongCnt", longCnt, 0);

      // Reset two cycles into a pending press; one rise after full latency
      riseBase = riseCnt;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("rstRiseCnt", riseCnt, riseBase + 1);
      checkOutput("rstRiseEdge", riseEdge, 6);

      // Pin toggling every two cycles never settles long enough to commit
      riseBase = riseCnt;
      fallBase = fallCnt;
      for (int i = 0; i < 100; i++) applyStimulus((i % 4) < 2, 1'b0);
      checkOutput("toggleRiseCnt", riseCnt, riseBase);
      checkOutput("toggleFallCnt", fallCnt, fallBase);
      checkOutput("toggleLevel", level, 1);

      // Release, then a fresh press held well past the long-press time
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
      riseBase = riseCnt;
      longBase = longCnt;
      applyStimulus(1'b0, 1'b0);
      pressEdge = lastDriveEdge;
      for (int i = 0; i < 44; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("longRiseCnt", riseCnt, riseBase + 1);
      checkOutput("longRiseEdge", riseEdge, pressEdge + 5);
`ifdef DEBOUNCED_INPUT_LONGPRESS_EN
      checkOutput("longPulseCnt", longCnt, longBase + 1);
      checkOutput("longPulseEdge", longEdge, riseEdge + 20);
`else
      checkOutput("longPulseCnt", longCnt, longBase);
`endif

      // Let the monitor consume the last expectation
      @(negedge clk);
      @(negedge clk);
      checkOutput("queueDrained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
